// File: rtl/ysyx_22050039_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings, instruction function codes
// and the small decode helpers used by the IDU/EXU side as well.
package ysyx_22050039_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StTrap   = 3'd6
    } state_e;

    localparam logic [2:0] FuncAddi   = 3'd0;
    localparam logic [2:0] FuncJalr   = 3'd1;
    localparam logic [2:0] FuncAuipc  = 3'd2;
    localparam logic [2:0] FuncLui    = 3'd3;
    localparam logic [2:0] FuncSd     = 3'd4;
    localparam logic [2:0] FuncJal    = 3'd5;
    localparam logic [2:0] FuncEbreak = 3'd6;

    localparam int unsigned TimeoutDefault = 16;

    function automatic logic func_writes_rd(input logic [2:0] f);
        return (f == FuncAddi) || (f == FuncJalr) || (f == FuncAuipc) ||
               (f == FuncLui)  || (f == FuncJal);
    endfunction

    function automatic logic func_is_jump(input logic [2:0] f);
        return (f == FuncJalr) || (f == FuncJal);
    endfunction

endpackage

// File: rtl/ysyx_22050039_seq_ctrl_wdog.sv
// Handshake wait counter: cleared on state entry, counts waiting cycles, flags the last
// permitted wait cycle so the caller can trap if no response arrives in it.
module ysyx_22050039_wdog #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] cnt_q;

    assign expire = (cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_22050039_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with halt on ebreak and
// sticky traps for illegal instructions and handshake timeouts.
module ysyx_22050039_seq_ctrl
    import ysyx_22050039_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = TimeoutDefault,
    parameter int unsigned TO_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req,
    input  logic            ifu_rvalid,
    output logic            inst_en,
    input  logic            dec_valid,
    input  logic [2:0]      dec_func,
    output logic            lsu_req,
    output logic            lsu_we,
    input  logic            lsu_done,
    output logic            rf_wen,
    output logic            pc_adv,
    output logic            pc_wen,
    output logic            halt,
    output logic            illegal,
    output logic            timeout,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret
);

    state_e            state_q, state_d;
    logic [2:0]        func_q;
    logic              halt_q, illegal_q, timeout_q;
    logic [XLEN-1:0]   cycle_q, instret_q;
    logic              set_halt, set_illegal, set_timeout, retire;
    logic              wd_clr, wd_en, wd_expire;

    always_comb begin
        state_d     = state_q;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        retire      = 1'b0;
        unique case (state_q)
            StFetch: begin
                // A response in the final wait cycle still wins over the trap.
                if (ifu_rvalid) begin
                    state_d = StDecode;
                end else if (wd_expire) begin
                    state_d     = StTrap;
                    set_timeout = 1'b1;
                end
            end
            StDecode: begin
                if (!dec_valid || (dec_func > FuncEbreak)) begin
                    state_d     = StTrap;
                    set_illegal = 1'b1;
                end else if (dec_func == FuncEbreak) begin
                    state_d  = StHalt;
                    set_halt = 1'b1;
                    retire   = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: state_d = (func_q == FuncSd) ? StMem : StWb;
            StMem: begin
                if (lsu_done) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (wd_expire) begin
                    state_d     = StTrap;
                    set_timeout = 1'b1;
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: state_d = state_q;
        endcase
    end

    // Clearing on every state change guarantees a zero count on entry to FETCH and MEM.
    assign wd_clr = rst || (state_d != state_q);
    assign wd_en  = ((state_q == StFetch) && !ifu_rvalid) || ((state_q == StMem) && !lsu_done);

    ysyx_22050039_wdog #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) u_wdog (
        .clk   (clk),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            func_q    <= FuncAddi;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_q | set_halt;
            illegal_q <= illegal_q | set_illegal;
            timeout_q <= timeout_q | set_timeout;
            if (state_q == StDecode) begin
                func_q <= dec_func;
            end
            if ((state_q != StHalt) && (state_q != StTrap)) begin
                cycle_q <= cycle_q + XLEN'(1);
            end
            if (retire) begin
                instret_q <= instret_q + XLEN'(1);
            end
        end
    end

    // Strobes decode from state; inst_en and the MEM-stage pc_adv follow the handshake inputs.
    always_comb begin
        ifu_req = 1'b0;
        inst_en = 1'b0;
        lsu_req = 1'b0;
        lsu_we  = 1'b0;
        rf_wen  = 1'b0;
        pc_adv  = 1'b0;
        pc_wen  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    ifu_req = 1'b1;
                    inst_en = ifu_rvalid;
                end
                StMem: begin
                    lsu_req = 1'b1;
                    lsu_we  = 1'b1;
                    pc_adv  = lsu_done;
                end
                StWb: begin
                    rf_wen = func_writes_rd(func_q);
                    pc_adv = 1'b1;
                    pc_wen = func_is_jump(func_q);
                end
                default: ;
            endcase
        end
    end

    assign halt      = halt_q & ~rst;
    assign illegal   = illegal_q & ~rst;
    assign timeout   = timeout_q & ~rst;
    assign cycle_cnt = rst ? '0 : cycle_q;
    assign instret   = rst ? '0 : instret_q;

endmodule
